// File: rtl/ldtu_ififo_cfg_ctrl.sv
// LiTe-DTU iFIFO configuration sequencer: applies gain/shift/threshold updates at a
// baseline quiet point, then flushes and refills the iFIFO. Optional macro: LDTU_CFG_TIMEOUT_EN.
module ldtu_ififo_cfg_ctrl #(
  parameter int unsigned QUIET_LEN  = 8,
  parameter int unsigned FLUSH_LEN  = 2,
  parameter int unsigned SETTLE_LEN = 8,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_BITS   = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_gain_sel_mode,
  input  logic [1:0]  cfg_shift_gain_10,
  input  logic [11:0] cfg_saturation_value,
  input  logic        baseline_flag,
  output logic        cfg_ack,
  output logic        cfg_busy,
  output logic [1:0]  GAIN_SEL_MODE,
  output logic [1:0]  shift_gain_10,
  output logic [11:0] SATURATION_value,
  output logic        fifo_rst_b,
  output logic        data_valid,
  output logic        forced
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_QUIET = 2'd1;
  localparam logic [1:0] FLUSH      = 2'd2;
  localparam logic [1:0] SETTLE     = 2'd3;

  localparam logic [CNT_BITS-1:0] QUIET_LAST  = CNT_BITS'(QUIET_LEN - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_LAST  = CNT_BITS'(FLUSH_LEN - 1);
  localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_LEN - 1);

  logic [1:0]          state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic [1:0]          sh_mode, sh_shift;
  logic [11:0]         sh_sat;
  logic                capture, apply_sat, apply_all;
  logic                same_mode_shift;

  assign same_mode_shift = (cfg_gain_sel_mode == GAIN_SEL_MODE) &&
                           (cfg_shift_gain_10 == shift_gain_10);

`ifdef LDTU_CFG_TIMEOUT_EN
  localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);
  logic [TO_BITS-1:0] tcnt;
  logic               force_set;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    apply_sat = 1'b0;
    apply_all = 1'b0;
`ifdef LDTU_CFG_TIMEOUT_EN
    force_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cfg_req) begin
          capture = 1'b1;
          // Threshold-only updates do not change FIFO content meaning: no flush.
          if (same_mode_shift) begin
            apply_sat = 1'b1;
          end else begin
            state_nxt = WAIT_QUIET;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT_QUIET: begin
        if (baseline_flag && (cnt == QUIET_LAST)) begin
          apply_all = 1'b1;
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (baseline_flag) begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end else begin
          cnt_nxt = '0;
        end
`ifdef LDTU_CFG_TIMEOUT_EN
        // A quiet apply on the expiry cycle wins and is not reported as forced.
        if (!apply_all && (tcnt == TO_LAST)) begin
          apply_all = 1'b1;
          force_set = 1'b1;
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end
`endif
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      default: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state            <= FLUSH;
      cnt              <= '0;
      sh_mode          <= 2'b00;
      sh_shift         <= 2'b00;
      sh_sat           <= 12'hfff;
      GAIN_SEL_MODE    <= 2'b00;
      shift_gain_10    <= 2'b00;
      SATURATION_value <= 12'hfff;
      cfg_ack          <= 1'b0;
      cfg_busy         <= 1'b1;
      fifo_rst_b       <= 1'b0;
      data_valid       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        sh_mode  <= cfg_gain_sel_mode;
        sh_shift <= cfg_shift_gain_10;
        sh_sat   <= cfg_saturation_value;
      end
      if (apply_sat) begin
        SATURATION_value <= cfg_saturation_value;
      end
      if (apply_all) begin
        GAIN_SEL_MODE    <= sh_mode;
        shift_gain_10    <= sh_shift;
        SATURATION_value <= sh_sat;
      end
      cfg_ack    <= apply_all | apply_sat;
      cfg_busy   <= (state_nxt != IDLE);
      fifo_rst_b <= (state_nxt != FLUSH);
      data_valid <= (state_nxt == IDLE) || (state_nxt == WAIT_QUIET);
    end
  end

`ifdef LDTU_CFG_TIMEOUT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tcnt   <= '0;
      forced <= 1'b0;
    end else begin
      tcnt <= ((state == WAIT_QUIET) && (state_nxt == WAIT_QUIET)) ? tcnt + TO_BITS'(1) : '0;
      if (force_set) begin
        forced <= 1'b1;
      end
    end
  end
`else
  assign forced = 1'b0;
`endif

endmodule

// File: tb/tb_ldtu_ififo_cfg_ctrl.sv
// Scoreboard bench for ldtu_ififo_cfg_ctrl: per-cycle expected outputs are queued from a
// timeline model of each request; a negedge monitor pops and compares them.
module tb_ldtu_ififo_cfg_ctrl;

  localparam int unsigned QL = 8;
  localparam int unsigned FL = 2;
  localparam int unsigned SL = 8;
  localparam int unsigned TO = 255;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cfg_req;
  logic [1:0]  cfg_gain_sel_mode;
  logic [1:0]  cfg_shift_gain_10;
  logic [11:0] cfg_saturation_value;
  logic        baseline_flag;
  logic        cfg_ack, cfg_busy, fifo_rst_b, data_valid, forced;
  logic [1:0]  GAIN_SEL_MODE, shift_gain_10;
  logic [11:0] SATURATION_value;

  ldtu_ififo_cfg_ctrl #(
    .QUIET_LEN(QL), .FLUSH_LEN(FL), .SETTLE_LEN(SL), .TIMEOUT(TO), .CNT_BITS(8)
  ) dut (
    .CLK(CLK), .reset(reset), .cfg_req(cfg_req),
    .cfg_gain_sel_mode(cfg_gain_sel_mode), .cfg_shift_gain_10(cfg_shift_gain_10),
    .cfg_saturation_value(cfg_saturation_value), .baseline_flag(baseline_flag),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .GAIN_SEL_MODE(GAIN_SEL_MODE),
    .shift_gain_10(shift_gain_10), .SATURATION_value(SATURATION_value),
    .fifo_rst_b(fifo_rst_b), .data_valid(data_valid), .forced(forced)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic        ack, busy, rst_b, dv, frc;
    logic [1:0]  mode, shift;
    logic [11:0] sat;
  } vec_t;

  int unsigned exp_c[$];
  vec_t        exp_v[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: currently applied configuration and sticky forced flag.
  logic [1:0]  m_mode, m_shift;
  logic [11:0] m_sat;
  logic        m_forced;

  vec_t act;
  assign act = {cfg_ack, cfg_busy, fifo_rst_b, data_valid, forced,
                GAIN_SEL_MODE, shift_gain_10, SATURATION_value};

  function automatic vec_t mk(input logic ack, input logic busy, input logic rst_b, input logic dv);
    vec_t v;
    v.ack = ack; v.busy = busy; v.rst_b = rst_b; v.dv = dv; v.frc = m_forced;
    v.mode = m_mode; v.shift = m_shift; v.sat = m_sat;
    return v;
  endfunction

  task automatic push(input int unsigned c, input vec_t v);
    exp_c.push_back(c);
    exp_v.push_back(v);
  endtask

  always @(negedge CLK) begin
    vec_t e;
    while (exp_c.size() > 0 && exp_c[0] < cyc) begin
      vectors++; miscompares++;
      $display("FAIL missed_check cyc=%0d actual=unchecked required=checked", exp_c[0]);
      void'(exp_c.pop_front()); void'(exp_v.pop_front());
    end
    if (exp_c.size() > 0 && exp_c[0] == cyc) begin
      void'(exp_c.pop_front());
      e = exp_v.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d actual ack/busy/rstb/dv/frc=%b%b%b%b%b mode=%b shift=%b sat=%h required %b%b%b%b%b mode=%b shift=%b sat=%h",
                 cyc, act.ack, act.busy, act.rst_b, act.dv, act.frc, act.mode, act.shift, act.sat,
                 e.ack, e.busy, e.rst_b, e.dv, e.frc, e.mode, e.shift, e.sat);
      end
    end else if (cfg_ack !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL spurious_ack cyc=%0d actual=%b required=0", cyc, cfg_ack);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    int unsigned r;
    #1;
    cfg_req = 1'b0;
    reset = 1'b1;
    exp_c.delete(); exp_v.delete();
    m_mode = 2'b00; m_shift = 2'b00; m_sat = 12'hfff; m_forced = 1'b0;
    push(cyc + 1, mk(1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    #1;
    reset = 1'b0;
    r = cyc;
    for (int unsigned k = 1; k <= 10; k++)
      push(r + k, mk(1'b0, k < FL + SL, k >= FL, k >= FL + SL));
    for (int unsigned k = 1; k <= 10; k++) tick();
  endtask

  // Threshold-only request; hold=2 keeps cfg_req high one more IDLE cycle (a second request).
  task automatic thresh(input logic [11:0] st, input int unsigned hold);
    int unsigned t0;
    logic [11:0] vals [2];
    t0 = cyc;
    vals[0] = st;
    vals[1] = 12'($urandom);
    cfg_req = 1'b1;
    cfg_gain_sel_mode = m_mode;
    cfg_shift_gain_10 = m_shift;
    cfg_saturation_value = vals[0];
    for (int unsigned k = 1; k <= hold; k++) begin
      m_sat = vals[k-1];
      push(t0 + k, mk(1'b1, 1'b0, 1'b1, 1'b1));
    end
    push(t0 + hold + 1, mk(1'b0, 1'b0, 1'b1, 1'b1));
    for (int unsigned k = 1; k <= hold; k++) begin
      tick();
      if (k < hold) cfg_saturation_value = vals[k];
      else cfg_req = 1'b0;
    end
    tick();
  endtask

  // Mode/shift change. pat: 0 quiet, 1 single drop at drop_at, 2 random drops, 3 never quiet.
  task automatic change(input logic [1:0] md, input logic [1:0] sh, input logic [11:0] st,
                        input int unsigned pat, input int unsigned drop_at, input int unsigned abort_k);
    bit b [1100];
    int unsigned t0, c, run, a, last;
    logic frc;
    t0 = cyc;
    for (int unsigned k = 0; k < 1100; k++) begin
      case (pat)
        0: b[k] = 1'b1;
        1: b[k] = (k != drop_at);
        2: b[k] = ($urandom_range(0, 5) != 0) || (k >= 150);
        default: b[k] = 1'b0;
      endcase
    end
    // First cycle that closes a run of QL baseline cycles.
    c = 0; run = 0;
    for (int unsigned k = 0; k < 1100 && c == 0; k++) begin
      run = b[k] ? run + 1 : 0;
      if (run >= QL) c = k + 1;
    end
    frc = 1'b0;
`ifdef LDTU_CFG_TIMEOUT_EN
    if (c == 0 || c > TO) begin
      c = TO;
      frc = 1'b1;
    end
`endif
    cfg_req = 1'b1;
    cfg_gain_sel_mode = md;
    cfg_shift_gain_10 = sh;
    cfg_saturation_value = st;
    if (c == 0) begin
      for (int unsigned k = 1; k <= 1000; k++) push(t0 + k, mk(1'b0, 1'b1, 1'b1, 1'b1));
      for (int unsigned k = 1; k <= 1000; k++) begin
        tick();
        baseline_flag = b[k-1];
        cfg_saturation_value = 12'($urandom);
      end
    end else begin
      a = c + 1;
      last = a + FL + SL;
      for (int unsigned k = 1; k <= last; k++) begin
        if (k == a) begin
          m_mode = md; m_shift = sh; m_sat = st;
          if (frc) m_forced = 1'b1;
        end
        push(t0 + k, mk(k == a, k < last, !(k >= a && k < a + FL), (k < a) || (k == last)));
      end
      for (int unsigned k = 1; k <= last; k++) begin
        tick();
        if (abort_k != 0 && k == abort_k) begin
          do_reset();
          return;
        end
        baseline_flag = b[k-1];
        if (k == a) cfg_req = 1'b0;
        cfg_gain_sel_mode = 2'($urandom);
        cfg_shift_gain_10 = 2'($urandom);
        cfg_saturation_value = 12'($urandom);
      end
      baseline_flag = 1'b1;
    end
  endtask

  initial begin
    logic [1:0]  md, sh;
    logic [11:0] st;
    reset = 1'b1;
    cfg_req = 1'b0;
    cfg_gain_sel_mode = 2'b00;
    cfg_shift_gain_10 = 2'b00;
    cfg_saturation_value = 12'h000;
    baseline_flag = 1'b1;
    m_mode = 2'b00; m_shift = 2'b00; m_sat = 12'hfff; m_forced = 1'b0;
    tick();
    do_reset();

    change(2'b01, 2'b00, 12'hfff, 0, 0, 0);
    change(2'b10, 2'b01, 12'h123, 1, 4, 0);
    thresh(12'h800, 1);
    thresh(12'h5a5, 2);

    for (int unsigned i = 0; i < 10; i++) begin
      md = 2'($urandom);
      sh = 2'($urandom);
      st = 12'($urandom);
      if ((md == m_mode && sh == m_shift) || $urandom_range(0, 3) == 0)
        thresh(st, $urandom_range(1, 2));
      else
        change(md, sh, st, $urandom_range(0, 2), $urandom_range(0, 10), 0);
    end

    // Reset in the middle of SETTLE: applied and shadow values revert.
    change(m_mode ^ 2'b01, m_shift, 12'h3c3, 0, 0, QL + 1 + FL + 3);
    thresh(12'h0f0, 1);

    // Baseline never quiet.
    change(m_mode ^ 2'b10, m_shift, 12'h456, 3, 0, 0);
`ifdef LDTU_CFG_TIMEOUT_EN
    thresh(12'h789, 1);
`else
    do_reset();
`endif

    tick(); tick();
    if (exp_c.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL leftover_checks actual=%0d required=0", exp_c.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldtu_ififo_cfg_ctrl.md
# ldtu_ififo_cfg_ctrl

Configuration sequencer for the LiTe-DTU input FIFO / gain-selection stage. Accepts gain-selection mode, gain-10 shift and saturation-threshold updates from the register side through a req/ack handshake. Changes that alter the FIFO contents' meaning are applied only at a quiet point, where the stream is baseline. After such a change it flushes the input FIFOs and masks the output until the pipeline has refilled. It sits between the configuration registers and the iFIFO, and drives the iFIFO's active-low reset and configuration inputs.

## Interface

Parameters:
- QUIET_LEN, 8: consecutive `baseline_flag`=1 cycles required before applying a change.
- FLUSH_LEN, 2: cycles `fifo_rst_b` is held low.
- SETTLE_LEN, 8: refill cycles after flush (FIFO depth).
- TIMEOUT, 255: maximum WAIT_QUIET cycles. Only used when `LDTU_CFG_TIMEOUT_EN` is defined.
- CNT_BITS, 8: width of the shared state counter.

Ports:
- CLK  in  1  LiTe-DTU clock. This is the only clock.
- reset  in  1  Asynchronous, active-high reset.
- cfg_req  in  1  Level request to apply the `cfg_*` values.
- cfg_gain_sel_mode  in  2  Requested GAIN_SEL_MODE.
- cfg_shift_gain_10  in  2  Requested gain-10 shift.
- cfg_saturation_value  in  12  Requested saturation threshold.
- baseline_flag  in  1  Baseline indicator from the iFIFO.
- cfg_ack  out  1  One-cycle pulse when the configuration is applied.
- cfg_busy  out  1  High from request capture until return to IDLE.
- GAIN_SEL_MODE  out  2  Applied mode.
- shift_gain_10  out  2  Applied shift.
- SATURATION_value  out  12  Applied threshold.
- fifo_rst_b  out  1  Active-low reset to the iFIFO.
- data_valid  out  1  High when the iFIFO output is trustworthy.
- forced  out  1  Sticky flag: at least one apply was forced by timeout.

## Operation

- All outputs are registered.
- Reset values:
  - GAIN_SEL_MODE=2'b00, shift_gain_10=2'b00, SATURATION_value=12'hfff.
  - fifo_rst_b=0, data_valid=0, cfg_ack=0, cfg_busy=1, forced=0.
  - Reset enters state FLUSH with counter=0. Reset asserted at any point aborts the pending request and discards the shadow registers.
- States:
  - IDLE: cfg_busy=0, data_valid=1. On cfg_req=1, capture all three `cfg_*` fields into shadow registers.
    - If the shadow mode and shift both equal the applied values (threshold-only change): apply the threshold next cycle, pulse cfg_ack, stay in IDLE. There is no flush and data_valid stays 1.
    - Otherwise: go to WAIT_QUIET with counter=0 and cfg_busy=1.
  - WAIT_QUIET: data_valid=1.
    - Counter increments while baseline_flag=1 and clears to 0 when baseline_flag=0.
    - When baseline_flag=1 with counter=QUIET_LEN-1, apply all shadow values, pulse cfg_ack, and go to FLUSH.
  - FLUSH: fifo_rst_b=0, data_valid=0. After FLUSH_LEN cycles, go to SETTLE.
  - SETTLE: fifo_rst_b=1, data_valid=0. After SETTLE_LEN cycles, go to IDLE.
- Handshake:
  - The requester holds cfg_req until it sees cfg_ack, then deasserts it.
  - cfg_req and `cfg_*` are ignored outside IDLE. Changing `cfg_*` while busy has no effect.
  - cfg_req still high on the IDLE cycle after a threshold-only ack is treated as a new request.
- Counter: a single CNT_BITS counter is shared by WAIT_QUIET, FLUSH and SETTLE. It reloads to 0 on every state change and does not wrap within any state.
- Simultaneous events:
  - An apply cycle and baseline_flag dropping in that same cycle cannot both occur: the apply condition requires baseline_flag=1.
  - A timeout expiry coinciding with the quiet condition counts as a normal apply. forced is not set.

## Timing

- Request sampled in IDLE at cycle 0 → cfg_busy=1 at cycle 1.
- With baseline_flag constantly 1: the apply condition is met at cycle QUIET_LEN. New config outputs and cfg_ack=1 appear at cycle QUIET_LEN+1.
- fifo_rst_b=0 for cycles QUIET_LEN+1 … QUIET_LEN+FLUSH_LEN.
- data_valid returns to 1 and cfg_busy to 0 at cycle QUIET_LEN+1+FLUSH_LEN+SETTLE_LEN.
- Threshold-only request at cycle 0 → new SATURATION_value and cfg_ack at cycle 1.
- After reset deasserts: fifo_rst_b=1 after FLUSH_LEN rising edges; data_valid=1 after FLUSH_LEN+SETTLE_LEN edges.

## Configuration

- `LDTU_CFG_TIMEOUT_EN` defined:
  - WAIT_QUIET also counts total cycles in that state.
  - On reaching TIMEOUT, the block applies the shadow values, pulses cfg_ack, sets forced=1 and goes to FLUSH.
  - forced clears only on reset.
- Not defined: WAIT_QUIET waits indefinitely for the quiet condition, and forced is tied to 0.

## Test plan

- Reset release → fifo_rst_b goes 0→1 at the 2nd edge and data_valid goes 1 at the 10th edge. Outputs read 00/00/12'hfff.
- IDLE, cfg_req with mode 2'b01, baseline_flag=1 throughout → cfg_ack and GAIN_SEL_MODE=01 at cycle 9; fifo_rst_b low at cycles 9–10; data_valid=1 at cycle 19.
- Same request, baseline_flag=0 for one cycle at cycle 5 → quiet count restarts and cfg_ack moves to cycle 14.
- Threshold-only change to 12'h800 → SATURATION_value=12'h800 and cfg_ack at cycle 1. fifo_rst_b and data_valid stay 1.
- baseline_flag held 0, mode change requested:
  - With macro: cfg_ack at cycle 256 and forced=1.
  - Without macro: no cfg_ack within 1000 cycles, cfg_busy stays 1.
- Reset asserted mid-SETTLE of a mode change → all outputs go immediately to reset values. The previous shadow config is not applied, and the power-up sequence repeats.
